// File: rtl/cory_demux_mc_if.sv
// Producer/consumer bundle for cory_demux_mc: data, destination mask and the
// M per-channel output streams.
interface cory_demux_mc_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
);
  logic           i_a_v;
  logic [N-1:0]   i_a_d;
  logic           o_a_r;
  logic           i_s_v;
  logic [M-1:0]   i_s_d;
  logic           o_s_r;
  logic [M-1:0]   o_z_v;
  logic [M*N-1:0] o_z_d;
  logic [M-1:0]   i_z_r;

  modport slave (
    input  i_a_v, i_a_d, i_s_v, i_s_d, i_z_r,
    output o_a_r, o_s_r, o_z_v, o_z_d
  );

  modport master (
    output i_a_v, i_a_d, i_s_v, i_s_d, i_z_r,
    input  o_a_r, o_s_r, o_z_v, o_z_d
  );
endinterface

// File: rtl/cory_demux_mc.sv
// Multicast valid/ready demux: one input beat goes to any subset of M channels,
// each buffered in a D-deep FIFO, with partial delivery tracked in a done mask.
module cory_demux_mc #(
  parameter int unsigned N  = 8,
  parameter int unsigned M  = 4,
  parameter int unsigned D  = 2,
  parameter int unsigned CW = 8
) (
  input  logic            clk,
  input  logic            reset,
  cory_demux_mc_if.slave  bus,
  output logic            o_busy,
  output logic [CW-1:0]   o_drop_cnt
);
  localparam int unsigned PW   = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned CNTW = $clog2(D + 1);

  logic [N-1:0]    mem    [M][D];
  logic [PW-1:0]   wr_ptr [M];
  logic [PW-1:0]   rd_ptr [M];
  logic [CNTW-1:0] cnt    [M];
  logic [M-1:0]    dm;
  logic [M-1:0]    full;
  logic [M-1:0]    valid;
  logic [M-1:0]    wr;
  logic [M-1:0]    pop;
  logic            req;
  logic            done;

  // Pointers wrap explicitly so D need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full  = '0;
    valid = '0;
    wr    = '0;
    pop   = '0;
    req   = bus.i_a_v && bus.i_s_v;
    for (int k = 0; k < M; k++) begin
      full[k]  = (cnt[k] == CNTW'(D));
      valid[k] = (cnt[k] != '0);
      wr[k]    = req && bus.i_s_d[k] && !dm[k] && !full[k];
      pop[k]   = valid[k] && bus.i_z_r[k];
    end
    done = req && ((bus.i_s_d & ~(dm | wr)) == '0);
  end

  // Unoccupied channels drive zero data.
  always_comb begin
    bus.o_z_d = '0;
    for (int k = 0; k < M; k++) begin
      if (valid[k]) bus.o_z_d[k*N +: N] = mem[k][rd_ptr[k]];
    end
  end

  assign bus.o_a_r = done;
  assign bus.o_s_r = done;
  assign bus.o_z_v = valid;
  assign o_busy    = |dm;

  always_ff @(posedge clk) begin
    if (reset) begin
      dm         <= '0;
      o_drop_cnt <= '0;
      for (int k = 0; k < M; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      if (done)     dm <= '0;
      else if (req) dm <= dm | wr;
      if (done && (bus.i_s_d == '0) && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + CW'(1);
      for (int k = 0; k < M; k++) begin
        if (wr[k])  wr_ptr[k] <= ptr_inc(wr_ptr[k]);
        if (pop[k]) rd_ptr[k] <= ptr_inc(rd_ptr[k]);
        if (wr[k] && !pop[k])      cnt[k] <= cnt[k] + CNTW'(1);
        else if (!wr[k] && pop[k]) cnt[k] <= cnt[k] - CNTW'(1);
      end
    end
  end

  // Storage carries no reset; emptiness is tracked by the counters.
  always_ff @(posedge clk) begin
    for (int k = 0; k < M; k++) begin
      if (wr[k]) mem[k][wr_ptr[k]] <= bus.i_a_d;
    end
  end
endmodule
